// File: rtl/hilo_unit.sv
// HI/LO register pair with independent half writes, full-width writes and a
// two-cycle MADD/MSUB accumulate that can be cancelled by a pipeline flush.
module hilo_unit #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [2:0]      op,
  input  logic [2*DW-1:0] op_wdata,
  output logic [DW-1:0]   hi,
  output logic [DW-1:0]   lo,
  output logic            busy,
  output logic            acc_done
);

  typedef enum logic {
    IDLE,
    ACC
  } state_t;

  localparam logic [2:0] OpMthi = 3'b000;
  localparam logic [2:0] OpMtlo = 3'b001;
  localparam logic [2:0] OpWr64 = 3'b010;
  localparam logic [2:0] OpMadd = 3'b011;
  localparam logic [2:0] OpMsub = 3'b100;

  state_t          state_q, state_d;
  logic [DW-1:0]   hi_q, hi_d;
  logic [DW-1:0]   lo_q, lo_d;
  logic [2*DW-1:0] operand_q, operand_d;
  logic            sub_q, sub_d;
  logic            accDone_q, accDone_d;

  logic            accept;
  logic [2*DW-1:0] accSum;

  assign op_ready = (state_q == IDLE) & ~flush;
  assign accept   = op_valid & op_ready;
  assign busy     = (state_q == ACC);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign acc_done = accDone_q;

  // Plain 2*DW-bit wrap-around; the operand is already a full-width product.
  assign accSum = sub_q ? ({hi_q, lo_q} - operand_q)
                        : ({hi_q, lo_q} + operand_q);

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    operand_d = operand_q;
    sub_d     = sub_q;
    accDone_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          case (op)
            OpMthi: hi_d = op_wdata[DW-1:0];
            OpMtlo: lo_d = op_wdata[DW-1:0];
            OpWr64: {hi_d, lo_d} = op_wdata;
            OpMadd: begin
              operand_d = op_wdata;
              sub_d     = 1'b0;
              state_d   = ACC;
            end
            OpMsub: begin
              operand_d = op_wdata;
              sub_d     = 1'b1;
              state_d   = ACC;
            end
            default: ;
          endcase
        end
      end
      ACC: begin
        // A flush cancels the in-flight accumulate without touching hi/lo.
        state_d = IDLE;
        if (!flush) begin
          {hi_d, lo_d} = accSum;
          accDone_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      operand_q <= '0;
      sub_q     <= 1'b0;
      accDone_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      operand_q <= operand_d;
      sub_q     <= sub_d;
      accDone_q <= accDone_d;
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: a vector table of ops with hand-computed results
// plus hand-written sequences for back-to-back, flush and reset-mid-accumulate.
module tb_hilo_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        opValid;
  logic        opReady;
  logic [2:0]  op;
  logic [63:0] opWdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        accDone;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] wdata;
    logic [63:0] expHiLo;
  } vec_t;

  vec_t vecs[10];

  hilo_unit #(.DW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .op_valid (opValid),
    .op_ready (opReady),
    .op       (op),
    .op_wdata (opWdata),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .acc_done (accDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Presents one op for a single accepting edge, then drops op_valid.
  task automatic applyStimulus(input logic [2:0] opCode, input logic [63:0] wdata);
    opValid = 1'b1;
    op      = opCode;
    opWdata = wdata;
    step();
    opValid = 1'b0;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst     = 1'b0;
    flush   = 1'b0;
    opValid = 1'b0;
    op      = 3'b000;
    opWdata = '0;

    vecs[0] = '{3'b000, 64'h00000000_DEADBEEF, 64'hDEADBEEF_00000000};
    vecs[1] = '{3'b001, 64'h00000000_12345678, 64'hDEADBEEF_12345678};
    vecs[2] = '{3'b000, 64'hFFFFFFFF_00000011, 64'h00000011_12345678};
    vecs[3] = '{3'b101, 64'hFFFFFFFF_FFFFFFFF, 64'h00000011_12345678};
    vecs[4] = '{3'b010, 64'h00000001_FFFFFFFF, 64'h00000001_FFFFFFFF};
    vecs[5] = '{3'b011, 64'h00000000_00000001, 64'h00000002_00000000};
    vecs[6] = '{3'b010, 64'h00000000_00000000, 64'h00000000_00000000};
    vecs[7] = '{3'b100, 64'h00000000_00000001, 64'hFFFFFFFF_FFFFFFFF};
    vecs[8] = '{3'b011, 64'h00000000_00000001, 64'h00000000_00000000};
    vecs[9] = '{3'b111, 64'h12345678_9ABCDEF0, 64'h00000000_00000000};

    // Asynchronous reset between clock edges must take effect immediately.
    #2 rst = 1'b1;
    #1;
    checkOutput("reset hilo", {hi, lo}, 64'h0);
    checkOutput("reset busy", {63'h0, busy}, 64'h0);
    checkOutput("reset op_ready", {63'h0, opReady}, 64'h1);
    checkOutput("reset acc_done", {63'h0, accDone}, 64'h0);
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].op, vecs[i].wdata);
      if (vecs[i].op == 3'b011 || vecs[i].op == 3'b100) begin
        checkOutput($sformatf("vec%0d acc busy", i), {63'h0, busy}, 64'h1);
        checkOutput($sformatf("vec%0d acc op_ready", i), {63'h0, opReady}, 64'h0);
        step();
        checkOutput($sformatf("vec%0d acc_done", i), {63'h0, accDone}, 64'h1);
        checkOutput($sformatf("vec%0d acc hilo", i), {hi, lo}, vecs[i].expHiLo);
        step();
        checkOutput($sformatf("vec%0d acc_done pulse", i), {63'h0, accDone}, 64'h0);
      end else begin
        checkOutput($sformatf("vec%0d hilo", i), {hi, lo}, vecs[i].expHiLo);
        checkOutput($sformatf("vec%0d busy", i), {63'h0, busy}, 64'h0);
      end
    end

    // Back-to-back: second MADD held through ACC, accepted in the acc_done cycle.
    applyStimulus(3'b010, 64'h00000000_0000000A);
    applyStimulus(3'b011, 64'h00000000_00000005);
    opValid = 1'b1;
    op      = 3'b011;
    opWdata = 64'h00000000_00000007;
    checkOutput("b2b op_ready in ACC", {63'h0, opReady}, 64'h0);
    step();
    checkOutput("b2b first result", {hi, lo}, 64'h00000000_0000000F);
    checkOutput("b2b acc_done", {63'h0, accDone}, 64'h1);
    checkOutput("b2b op_ready on done", {63'h0, opReady}, 64'h1);
    step();
    opValid = 1'b0;
    checkOutput("b2b second busy", {63'h0, busy}, 64'h1);
    checkOutput("b2b acc_done low", {63'h0, accDone}, 64'h0);
    step();
    checkOutput("b2b second result", {hi, lo}, 64'h00000000_00000016);
    checkOutput("b2b second acc_done", {63'h0, accDone}, 64'h1);

    // Flush in the ACC cycle cancels the accumulate; held op is not accepted.
    applyStimulus(3'b010, 64'h0000000A_0000000B);
    applyStimulus(3'b011, 64'h00000001_00000001);
    flush   = 1'b1;
    opValid = 1'b1;
    op      = 3'b000;
    opWdata = 64'h00000000_00000099;
    checkOutput("flush op_ready", {63'h0, opReady}, 64'h0);
    step();
    checkOutput("flush hilo", {hi, lo}, 64'h0000000A_0000000B);
    checkOutput("flush acc_done", {63'h0, accDone}, 64'h0);
    checkOutput("flush busy", {63'h0, busy}, 64'h0);
    checkOutput("flush idle op_ready", {63'h0, opReady}, 64'h0);
    step();
    checkOutput("flush blocks accept", {hi, lo}, 64'h0000000A_0000000B);
    flush   = 1'b0;
    opValid = 1'b0;
    step();
    checkOutput("flush no late commit", {hi, lo}, 64'h0000000A_0000000B);
    checkOutput("flush no late done", {63'h0, accDone}, 64'h0);

    // Reset asserted during ACC clears immediately and nothing commits later.
    applyStimulus(3'b010, 64'h00000000_00000005);
    applyStimulus(3'b011, 64'h00000000_00000003);
    checkOutput("rstacc busy before", {63'h0, busy}, 64'h1);
    rst = 1'b1;
    #1;
    checkOutput("rstacc hilo", {hi, lo}, 64'h0);
    checkOutput("rstacc busy", {63'h0, busy}, 64'h0);
    #1 rst = 1'b0;
    step();
    checkOutput("rstacc no commit", {hi, lo}, 64'h0);
    checkOutput("rstacc no done", {63'h0, accDone}, 64'h0);
    step();
    checkOutput("rstacc still zero", {hi, lo}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
